fsm_sequencer: RTL and testbench

Control and state-holding stage wrapped around the 5-state ring next-state logic. Owns the 3-bit state register, drives the current state `a` and the per-state advance enables `i0..i4` into the next-state logic, and registers its returned next state `y`. Adds run/idle control, a minimum per-state dwell time, lap counting, and illegal-state recovery.

---
 rtl/fsm_sequencer.sv | 157 +++++++++++++++
 tb/tb_fsm_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fsm_sequencer.sv
// Sequencer wrapped around the 5-state ring next-state logic: owns the state
// register, gates advance enables by run mode and dwell time, counts laps.
module fsm_sequencer #(
  parameter int unsigned DWELL = 2,
  parameter int unsigned CW    = 8,
  parameter int unsigned LAP_W = 8,
  parameter int unsigned LOOP  = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [4:0]       ev,
  input  logic [2:0]       y,
  output logic [2:0]       a,
  output logic             i0,
  output logic             i1,
  output logic             i2,
  output logic             i3,
  output logic             i4,
  output logic             busy,
  output logic             lap_done,
  output logic [LAP_W-1:0] laps,
  output logic             err
);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} mode_t;

  mode_t            mode_r, mode_s;
  logic [2:0]       st_r, st_s;
  logic [CW-1:0]    cnt_r, cnt_s, cnt_inc_s;
  logic [LAP_W-1:0] laps_r, laps_s;
  logic             lap_done_r, lap_s;
  logic             err_r, err_s;
  logic             ev_sel_s;
  logic             en_s;
  logic [4:0]       iv_s;

  // Event bit belonging to the current state
  always_comb begin
    ev_sel_s = 1'b0;
    case (st_r)
      3'd0:    ev_sel_s = ev[0];
      3'd1:    ev_sel_s = ev[1];
      3'd2:    ev_sel_s = ev[2];
      3'd3:    ev_sel_s = ev[3];
      3'd4:    ev_sel_s = ev[4];
      default: ev_sel_s = 1'b0;
    endcase
  end

  // Advance enable: running, event present, dwell satisfied
  always_comb begin
    en_s = 1'b0;
    iv_s = 5'b00000;
    if ((mode_r == RUN) && ev_sel_s && (cnt_r >= CW'(DWELL))) begin
      en_s = 1'b1;
    end else begin
      en_s = 1'b0;
    end
    if (en_s) begin
      iv_s = 5'b00001 << st_r;
    end else begin
      iv_s = 5'b00000;
    end
  end

  assign i0 = iv_s[0];
  assign i1 = iv_s[1];
  assign i2 = iv_s[2];
  assign i3 = iv_s[3];
  assign i4 = iv_s[4];

  assign cnt_inc_s = (cnt_r >= CW'(DWELL)) ? cnt_r : cnt_r + CW'(1);

  // Next mode, state, dwell count, lap and error bookkeeping
  always_comb begin
    mode_s = mode_r;
    st_s   = st_r;
    cnt_s  = cnt_inc_s;
    laps_s = laps_r;
    lap_s  = 1'b0;
    err_s  = err_r;
    if (abort) begin
      mode_s = IDLE;
      st_s   = 3'd0;
      cnt_s  = {CW{1'b0}};
    end else begin
      case (mode_r)
        IDLE: begin
          if (start) begin
            mode_s = RUN;
            cnt_s  = {CW{1'b0}};
          end else begin
            mode_s = IDLE;
          end
        end
        RUN: begin
          // Out-of-ring next state recovers to 0 and is never a lap
          if (y <= 3'd4) begin
            st_s = y;
          end else begin
            st_s  = 3'd0;
            err_s = 1'b1;
          end
          if (st_s != st_r) begin
            cnt_s = {CW{1'b0}};
          end else begin
            cnt_s = cnt_inc_s;
          end
          if ((st_r == 3'd4) && (y == 3'd0)) begin
            lap_s  = 1'b1;
            laps_s = laps_r + LAP_W'(1);
            if (LOOP == 0) begin
              mode_s = IDLE;
            end else begin
              mode_s = RUN;
            end
          end else begin
            lap_s = 1'b0;
          end
        end
        default: begin
          mode_s = IDLE;
          st_s   = 3'd0;
          cnt_s  = {CW{1'b0}};
        end
      endcase
    end
  end

  // Registered state with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      mode_r     <= IDLE;
      st_r       <= 3'd0;
      cnt_r      <= {CW{1'b0}};
      laps_r     <= {LAP_W{1'b0}};
      lap_done_r <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      mode_r     <= mode_s;
      st_r       <= st_s;
      cnt_r      <= cnt_s;
      laps_r     <= laps_s;
      lap_done_r <= lap_s;
      err_r      <= err_s;
    end
  end

  assign a        = st_r;
  assign busy     = (mode_r == RUN);
  assign lap_done = lap_done_r;
  assign laps     = laps_r;
  assign err      = err_r;

endmodule

// File: tb/tb_fsm_sequencer.sv
// Directed bench: two sequencers (default looping and one-shot/no-dwell) each
// closed through a bench-side ring next-state model.
module tb_fsm_sequencer;

  logic       clock;
  logic       reset;

  logic       a_start, a_abort;
  logic [4:0] a_ev;
  logic [2:0] a_y, a_a;
  logic       a_i0, a_i1, a_i2, a_i3, a_i4;
  logic       a_busy, a_lap_done, a_err;
  logic [7:0] a_laps;
  logic       force_en;
  logic [2:0] force_val;

  logic       b_start, b_abort;
  logic [4:0] b_ev;
  logic [2:0] b_y, b_a;
  logic       b_i0, b_i1, b_i2, b_i3, b_i4;
  logic       b_busy, b_lap_done, b_err;
  logic [1:0] b_laps;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  fsm_sequencer #(.DWELL(2), .CW(8), .LAP_W(8), .LOOP(1)) dut_a (
    .clock(clock), .reset(reset), .start(a_start), .abort(a_abort),
    .ev(a_ev), .y(a_y), .a(a_a),
    .i0(a_i0), .i1(a_i1), .i2(a_i2), .i3(a_i3), .i4(a_i4),
    .busy(a_busy), .lap_done(a_lap_done), .laps(a_laps), .err(a_err)
  );

  fsm_sequencer #(.DWELL(0), .CW(4), .LAP_W(2), .LOOP(0)) dut_b (
    .clock(clock), .reset(reset), .start(b_start), .abort(b_abort),
    .ev(b_ev), .y(b_y), .a(b_a),
    .i0(b_i0), .i1(b_i1), .i2(b_i2), .i3(b_i3), .i4(b_i4),
    .busy(b_busy), .lap_done(b_lap_done), .laps(b_laps), .err(b_err)
  );

  function automatic logic [2:0] ring(input logic [2:0] cur, input logic [4:0] en);
    logic [2:0] nxt;
    nxt = cur;
    if (cur <= 3'd4 && en[cur]) nxt = (cur == 3'd4) ? 3'd0 : cur + 3'd1;
    return nxt;
  endfunction

  assign a_y = force_en ? force_val : ring(a_a, {a_i4, a_i3, a_i2, a_i1, a_i0});
  assign b_y = ring(b_a, {b_i4, b_i3, b_i2, b_i1, b_i0});

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; force_en = 1'b0; force_val = 3'd0;
    a_start = 1'b0; a_abort = 1'b0; a_ev = 5'b00000;
    b_start = 1'b0; b_abort = 1'b0; b_ev = 5'b00000;
    step(); step();
    reset = 1'b0;
    check("rst_a", 32'(a_a), 32'd0);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_laps", 32'(a_laps), 32'd0);
    check("rst_err", 32'(a_err), 32'd0);
    check("rst_lapdone", 32'(a_lap_done), 32'd0);
    a_ev = 5'b11111;
    check("rst_en_idle", 32'({a_i4, a_i3, a_i2, a_i1, a_i0}), 32'd0);

    // Start pulse, then two full laps and a bit with every event held high
    a_start = 1'b1; step(); a_start = 1'b0;
    check("busy_rise", 32'(a_busy), 32'd1);
    for (int n = 0; n < 36; n++) begin
      check("lap_a", 32'(a_a), 32'((n / 3) % 5));
      check("lap_en", 32'({a_i4, a_i3, a_i2, a_i1, a_i0}),
            (n % 3 == 2) ? (32'd1 << ((n / 3) % 5)) : 32'd0);
      check("lap_pulse", 32'(a_lap_done), (n > 0 && n % 15 == 0) ? 32'd1 : 32'd0);
      check("lap_count", 32'(a_laps), 32'(n / 15));
      step();
    end

    // Now in state 2 with cnt=0: withhold its event
    a_ev = 5'b11011;
    #1;
    for (int n = 0; n < 10; n++) begin
      check("hold_a", 32'(a_a), 32'd2);
      check("hold_en", 32'({a_i4, a_i3, a_i2, a_i1, a_i0}), 32'd0);
      step();
    end
    a_ev = 5'b11111;
    #1;
    check("release_en", 32'({a_i4, a_i3, a_i2, a_i1, a_i0}), 32'b00100);
    step();
    check("release_a", 32'(a_a), 32'd3);

    // Abort in state 3 once dwell is met
    step(); step();
    check("pre_abort_en", 32'({a_i4, a_i3, a_i2, a_i1, a_i0}), 32'b01000);
    a_abort = 1'b1; step();
    check("abort_a", 32'(a_a), 32'd0);
    check("abort_busy", 32'(a_busy), 32'd0);
    check("abort_laps", 32'(a_laps), 32'd2);
    check("abort_lapdone", 32'(a_lap_done), 32'd0);
    a_start = 1'b1; step();
    check("abort_over_start", 32'(a_busy), 32'd0);
    a_abort = 1'b0; step(); a_start = 1'b0;
    check("restart_busy", 32'(a_busy), 32'd1);

    // Illegal next state from state 1
    step(); step(); step();
    check("pre_illegal_a", 32'(a_a), 32'd1);
    force_en = 1'b1; force_val = 3'd6;
    step();
    force_en = 1'b0;
    check("illegal_a", 32'(a_a), 32'd0);
    check("illegal_err", 32'(a_err), 32'd1);
    check("illegal_not_lap", 32'(a_lap_done), 32'd0);
    check("illegal_laps", 32'(a_laps), 32'd2);
    repeat (15) step();
    check("post_illegal_lap", 32'(a_lap_done), 32'd1);
    check("post_illegal_laps", 32'(a_laps), 32'd3);
    check("err_sticky", 32'(a_err), 32'd1);
    repeat (30) step();
    repeat (13) step();
    check("pre_reset_a", 32'(a_a), 32'd4);
    check("pre_reset_laps", 32'(a_laps), 32'd5);

    // Reset mid-dwell in state 4
    reset = 1'b1; step(); reset = 1'b0;
    check("reset_a", 32'(a_a), 32'd0);
    check("reset_busy", 32'(a_busy), 32'd0);
    check("reset_laps", 32'(a_laps), 32'd0);
    check("reset_err", 32'(a_err), 32'd0);
    check("reset_en", 32'({a_i4, a_i3, a_i2, a_i1, a_i0}), 32'd0);
    a_ev = 5'b00000;

    // One-shot, no dwell: one state per cycle, stop after a lap
    b_ev = 5'b11111;
    b_start = 1'b1; step(); b_start = 1'b0;
    for (int n = 0; n < 5; n++) begin
      check("b_a", 32'(b_a), 32'(n));
      check("b_busy", 32'(b_busy), 32'd1);
      check("b_lapdone_low", 32'(b_lap_done), 32'd0);
      step();
    end
    check("b_wrap_a", 32'(b_a), 32'd0);
    check("b_lapdone", 32'(b_lap_done), 32'd1);
    check("b_busy_fall", 32'(b_busy), 32'd0);
    check("b_laps1", 32'(b_laps), 32'd1);
    step();
    check("b_stay_a", 32'(b_a), 32'd0);
    check("b_pulse_end", 32'(b_lap_done), 32'd0);
    check("b_idle_en", 32'({b_i4, b_i3, b_i2, b_i1, b_i0}), 32'd0);
    for (int k = 2; k <= 4; k++) begin
      b_start = 1'b1; step(); b_start = 1'b0;
      repeat (5) step();
      check("b_laps", 32'(b_laps), 32'(k % 4));
    end
    check("b_err", 32'(b_err), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
